// File: rtl/ddr5_mc_pwr_seq.sv
// DDR5 per-MC power sequencer: staggers DRAM_PWROK after DDRIO VRs are good, releases DIMM
// resets together, powers down in reverse order, and latches per-MC VR faults.
module ddr5_mc_pwr_seq #(
  parameter int MC_SIZE   = 4,
  parameter int T_VR_TO   = 2000,
  parameter int T_STAGGER = 20,
  parameter int T_RST     = 400,
  parameter int CNT_W     = 12
) (
  input  logic               iClk,
  input  logic               iRst,
  input  logic               iSeqEn,
  input  logic               iAdrEvent,
  input  logic               iMemPwrGdFail,
  input  logic [MC_SIZE-1:0] iDramPwrgdDDRIO,
  output logic [MC_SIZE-1:0] oDramPwrOk,
  output logic [MC_SIZE-1:0] oFpgaDimmRst_n,
  output logic               oSeqDone,
  output logic               oSeqFault,
  output logic [MC_SIZE-1:0] oFaultMc,
  output logic [2:0]         oSeqState
);

  localparam int IDX_W = (MC_SIZE > 1) ? $clog2(MC_SIZE) : 1;
  localparam logic [CNT_W-1:0]   VR_TO_LAST = CNT_W'(T_VR_TO - 1);
  localparam logic [CNT_W-1:0]   STG_LAST   = CNT_W'(T_STAGGER - 1);
  localparam logic [CNT_W-1:0]   RST_LAST   = CNT_W'(T_RST - 1);
  localparam logic [MC_SIZE-1:0] POK_FIRST  = MC_SIZE'(1);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(MC_SIZE - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT_VR = 3'd1,
    S_STAGGER = 3'd2,
    S_RST_DLY = 3'd3,
    S_ON      = 3'd4,
    S_PWRDN   = 3'd5,
    S_FAULT   = 3'd6
  } state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   timer_q;
  logic [IDX_W-1:0]   idx_q;
  logic [MC_SIZE-1:0] pwrok_q;
  logic [MC_SIZE-1:0] rst_n_q;
  logic               done_q;
  logic               fault_q;
  logic [MC_SIZE-1:0] fault_mc_q;

  logic               vr_all_good;
  logic [MC_SIZE-1:0] flt_term;
  logic               flt_hit;
  logic [MC_SIZE-1:0] fault_mc_d;
  logic [CNT_W-1:0]   timer_inc_d;

  assign vr_all_good = &iDramPwrgdDDRIO;
  assign flt_term    = pwrok_q & ~iDramPwrgdDDRIO;
  // Fault detection is masked while an ADR flow owns the rails.
  assign flt_hit     = !iAdrEvent
                     && (state_q inside {S_STAGGER, S_RST_DLY, S_ON, S_PWRDN})
                     && (iMemPwrGdFail || (|flt_term));
  assign fault_mc_d  = (flt_term == '0) ? '1 : (fault_mc_q | flt_term);
  assign timer_inc_d = (&timer_q) ? timer_q : (timer_q + CNT_W'(1));

  // Sequencer state, timers and all registered outputs.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      idx_q      <= '0;
      pwrok_q    <= '0;
      rst_n_q    <= '0;
      done_q     <= 1'b0;
      fault_q    <= 1'b0;
      fault_mc_q <= '0;
    end else if (flt_hit) begin
      state_q    <= S_FAULT;
      timer_q    <= '0;
      pwrok_q    <= '0;
      rst_n_q    <= '0;
      done_q     <= 1'b0;
      fault_q    <= 1'b1;
      fault_mc_q <= fault_mc_d;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (iSeqEn) begin
            state_q    <= S_WAIT_VR;
            timer_q    <= '0;
            fault_mc_q <= '0;
          end else begin
            timer_q <= timer_inc_d;
          end
        end
        S_WAIT_VR: begin
          if (vr_all_good) begin
            pwrok_q <= POK_FIRST;
            timer_q <= '0;
            idx_q   <= IDX_W'(1);
            if (MC_SIZE == 1) begin
              state_q <= S_RST_DLY;
            end else begin
              state_q <= S_STAGGER;
            end
          end else if (timer_q == VR_TO_LAST) begin
            state_q    <= S_FAULT;
            timer_q    <= '0;
            fault_q    <= 1'b1;
            fault_mc_q <= ~iDramPwrgdDDRIO;
          end else if (!iSeqEn) begin
            state_q <= S_IDLE;
            timer_q <= '0;
          end else begin
            timer_q <= timer_inc_d;
          end
        end
        S_STAGGER: begin
          if (timer_q == STG_LAST) begin
            pwrok_q[idx_q] <= 1'b1;
            idx_q          <= idx_q + IDX_W'(1);
            timer_q        <= '0;
            if (idx_q == IDX_LAST) begin
              state_q <= S_RST_DLY;
            end else begin
              state_q <= S_STAGGER;
            end
          end else begin
            timer_q <= timer_inc_d;
          end
        end
        S_RST_DLY: begin
          if (timer_q == RST_LAST) begin
            state_q <= S_ON;
            timer_q <= '0;
            rst_n_q <= '1;
            done_q  <= 1'b1;
          end else begin
            timer_q <= timer_inc_d;
          end
        end
        S_ON: begin
          if (!iSeqEn && !iAdrEvent) begin
            state_q <= S_PWRDN;
            timer_q <= '0;
            rst_n_q <= '0;
            done_q  <= 1'b0;
          end else begin
            timer_q <= timer_inc_d;
          end
        end
        S_PWRDN: begin
          // PWROK is a thermometer code here, so a right shift drops the highest set bit.
          if (timer_q == STG_LAST) begin
            pwrok_q <= pwrok_q >> 1;
            timer_q <= '0;
            if ((pwrok_q >> 1) == '0) begin
              state_q <= S_IDLE;
            end else begin
              state_q <= S_PWRDN;
            end
          end else begin
            timer_q <= timer_inc_d;
          end
        end
        S_FAULT: begin
          if (!iSeqEn) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            fault_q <= 1'b0;
          end else begin
            timer_q <= timer_inc_d;
          end
        end
        default: begin
          state_q <= S_IDLE;
          timer_q <= '0;
          pwrok_q <= '0;
          rst_n_q <= '0;
          done_q  <= 1'b0;
          fault_q <= 1'b0;
        end
      endcase
    end
  end

  assign oDramPwrOk     = pwrok_q;
  assign oFpgaDimmRst_n = rst_n_q;
  assign oSeqDone       = done_q;
  assign oSeqFault      = fault_q;
  assign oFaultMc       = fault_mc_q;
  assign oSeqState      = state_q;

endmodule

// File: tb/tb_ddr5_mc_pwr_seq.sv
// Scoreboard bench for ddr5_mc_pwr_seq: stimulus pushes timed output snapshots, a negedge
// monitor pops and compares them against the DUT.
module tb_ddr5_mc_pwr_seq;

  logic       clk;
  logic       iRst;
  logic       iSeqEn;
  logic       iAdrEvent;
  logic       iMemPwrGdFail;
  logic [3:0] vr;
  logic [3:0] oDramPwrOk;
  logic [3:0] oFpgaDimmRst_n;
  logic       oSeqDone;
  logic       oSeqFault;
  logic [3:0] oFaultMc;
  logic [2:0] oSeqState;

  int n_chk = 0;
  int n_err = 0;
  int ecnt  = 0;

  typedef struct {
    int          at;
    string       tag;
    logic [16:0] exp;
  } exp_t;

  exp_t sb[$];

  ddr5_mc_pwr_seq dut (
    .iClk            (clk),
    .iRst            (iRst),
    .iSeqEn          (iSeqEn),
    .iAdrEvent       (iAdrEvent),
    .iMemPwrGdFail   (iMemPwrGdFail),
    .iDramPwrgdDDRIO (vr),
    .oDramPwrOk      (oDramPwrOk),
    .oFpgaDimmRst_n  (oFpgaDimmRst_n),
    .oSeqDone        (oSeqDone),
    .oSeqFault       (oSeqFault),
    .oFaultMc        (oFaultMc),
    .oSeqState       (oSeqState)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) ecnt <= ecnt + 1;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (edge %0d)", tag, obs, exp, ecnt);
    end
  endtask

  // Snapshot layout: {state, fault_mc, fault, done, rst_n, pwrok}
  function automatic logic [16:0] snap();
    return {oSeqState, oFaultMc, oSeqFault, oSeqDone, oFpgaDimmRst_n, oDramPwrOk};
  endfunction

  task automatic push(input int at, input string tag, input logic [2:0] st,
                      input logic [3:0] pok, input logic [3:0] rstn, input logic done,
                      input logic flt, input logic [3:0] fmc);
    exp_t e;
    e.at  = at;
    e.tag = tag;
    e.exp = {st, fmc, flt, done, rstn, pok};
    sb.push_back(e);
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while (sb.size() > 0 && k < budget) begin
      @(posedge clk);
      k++;
    end
    if (sb.size() > 0) begin
      chk_eq("sb_drain_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].at <= ecnt) begin
      exp_t e;
      e = sb.pop_front();
      chk_eq(e.tag, 32'(snap()), 32'(e.exp));
    end
  end

  task automatic bring_up(input string tg);
    int m;
    @(negedge clk);
    iSeqEn = 1'b1;
    vr     = 4'hF;
    m      = ecnt + 2;
    push(m - 1,   {tg, "_wait_vr"},   3'd1, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0);
    push(m,       {tg, "_pok_0001"},  3'd2, 4'h1, 4'h0, 1'b0, 1'b0, 4'h0);
    push(m + 19,  {tg, "_pok_hold"},  3'd2, 4'h1, 4'h0, 1'b0, 1'b0, 4'h0);
    push(m + 20,  {tg, "_pok_0011"},  3'd2, 4'h3, 4'h0, 1'b0, 1'b0, 4'h0);
    push(m + 40,  {tg, "_pok_0111"},  3'd2, 4'h7, 4'h0, 1'b0, 1'b0, 4'h0);
    push(m + 60,  {tg, "_pok_1111"},  3'd3, 4'hF, 4'h0, 1'b0, 1'b0, 4'h0);
    push(m + 459, {tg, "_rst_hold"},  3'd3, 4'hF, 4'h0, 1'b0, 1'b0, 4'h0);
    push(m + 460, {tg, "_on"},        3'd4, 4'hF, 4'hF, 1'b1, 1'b0, 4'h0);
    drain(600);
  endtask

  initial begin
    int p;
    int w;
    iRst          = 1'b1;
    iSeqEn        = 1'b0;
    iAdrEvent     = 1'b0;
    iMemPwrGdFail = 1'b0;
    vr            = 4'h0;
    push(2, "reset_hold", 3'd0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0);
    drain(10);
    @(negedge clk);
    iRst = 1'b0;
    push(ecnt + 1, "reset_idle", 3'd0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0);
    drain(10);

    // Power-up with all VRs good
    bring_up("up1");

    // Orderly power-down
    @(negedge clk);
    iSeqEn = 1'b0;
    p = ecnt + 1;
    push(p,      "dn_entry", 3'd5, 4'hF, 4'h0, 1'b0, 1'b0, 4'h0);
    push(p + 19, "dn_hold",  3'd5, 4'hF, 4'h0, 1'b0, 1'b0, 4'h0);
    push(p + 20, "dn_0111",  3'd5, 4'h7, 4'h0, 1'b0, 1'b0, 4'h0);
    push(p + 40, "dn_0011",  3'd5, 4'h3, 4'h0, 1'b0, 1'b0, 4'h0);
    push(p + 60, "dn_0001",  3'd5, 4'h1, 4'h0, 1'b0, 1'b0, 4'h0);
    push(p + 80, "dn_idle",  3'd0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0);
    drain(200);

    // VR stuck at 1011 -> timeout
    @(negedge clk);
    vr     = 4'hB;
    iSeqEn = 1'b1;
    w = ecnt + 1;
    push(w,        "to_wait",   3'd1, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0);
    push(w + 1999, "to_edge",   3'd1, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0);
    push(w + 2000, "to_fault",  3'd6, 4'h0, 4'h0, 1'b0, 1'b1, 4'h4);
    drain(2100);
    @(negedge clk);
    iSeqEn = 1'b0;
    push(ecnt + 1, "to_idle_sticky", 3'd0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h4);
    drain(10);

    // VR[2] drop while ON (bring-up also checks fault capture is cleared)
    bring_up("up2");
    @(negedge clk);
    vr = 4'hB;
    push(ecnt + 1, "vr_drop_fault", 3'd6, 4'h0, 4'h0, 1'b0, 1'b1, 4'h4);
    drain(10);
    @(negedge clk);
    iSeqEn = 1'b0;
    vr     = 4'hF;
    push(ecnt + 1, "vr_drop_idle", 3'd0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h4);
    drain(10);

    // ADR defers power-down; VR recovers before ADR ends
    bring_up("up3");
    @(negedge clk);
    iAdrEvent = 1'b1;
    @(negedge clk);
    iSeqEn = 1'b0;
    vr     = 4'hB;
    push(ecnt + 1,  "adr_hold_a", 3'd4, 4'hF, 4'hF, 1'b1, 1'b0, 4'h0);
    push(ecnt + 10, "adr_hold_b", 3'd4, 4'hF, 4'hF, 1'b1, 1'b0, 4'h0);
    drain(20);
    @(negedge clk);
    vr = 4'hF;
    @(negedge clk);
    iAdrEvent = 1'b0;
    p = ecnt + 1;
    push(p,      "adr_pwrdn", 3'd5, 4'hF, 4'h0, 1'b0, 1'b0, 4'h0);
    push(p + 80, "adr_idle",  3'd0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0);
    drain(200);

    // ADR ends with VR still low -> fault wins over power-down
    bring_up("up4");
    @(negedge clk);
    iAdrEvent = 1'b1;
    @(negedge clk);
    iSeqEn = 1'b0;
    vr     = 4'hB;
    push(ecnt + 5, "adr2_hold", 3'd4, 4'hF, 4'hF, 1'b1, 1'b0, 4'h0);
    drain(20);
    @(negedge clk);
    iAdrEvent = 1'b0;
    push(ecnt + 1, "adr2_fault", 3'd6, 4'h0, 4'h0, 1'b0, 1'b1, 4'h4);
    push(ecnt + 2, "adr2_idle",  3'd0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h4);
    drain(10);
    vr = 4'hF;

    // Aggregate PWRGD failure with no per-MC culprit -> all ones
    bring_up("up5");
    @(negedge clk);
    iMemPwrGdFail = 1'b1;
    push(ecnt + 1, "pgf_fault", 3'd6, 4'h0, 4'h0, 1'b0, 1'b1, 4'hF);
    @(negedge clk);
    iMemPwrGdFail = 1'b0;
    iSeqEn        = 1'b0;
    push(ecnt + 1, "pgf_idle", 3'd0, 4'h0, 4'h0, 1'b0, 1'b0, 4'hF);
    drain(10);

    // Reset pulse mid-stagger
    @(negedge clk);
    iSeqEn = 1'b1;
    vr     = 4'hF;
    p = ecnt + 2;
    push(p + 25, "rst_pre", 3'd2, 4'h3, 4'h0, 1'b0, 1'b0, 4'h0);
    drain(60);
    @(negedge clk);
    iRst   = 1'b1;
    iSeqEn = 1'b0;
    push(ecnt + 1, "rst_mid", 3'd0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0);
    @(negedge clk);
    iRst = 1'b0;
    push(ecnt + 1, "rst_after", 3'd0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0);
    drain(10);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
